axi_resp_burst_scheduler: RTL and testbench
===========================================

Name: axi_resp_burst_scheduler

Overview:
- Sequencing controller for the Master NI response path.
- Decides which AXI response channel (B write response or R read data) owns the response packetizer.
- Locks the grant on R for a whole read burst until the RLAST handshake, and applies a weighted R/B policy when both channels request.
- Drives the packetizer's active_channel/update_priority inputs and flags malformed R bursts.

Parameters:
HAS_WRITE, 1'b1, B channel served; when 0, b_valid is ignored and B is never granted.
HAS_READ, 1'b1, R channel served; when 0, r_valid is ignored and R is never granted.
R_WEIGHT, 2, max consecutive R bursts granted while b_valid is pending (>=1).
MAX_BURST_LEN, 256, max R beats per burst before the watchdog fires (AXI4 limit).

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
b_valid  input  1  B channel valid from the external slave
b_ready  input  1  B ready as driven by the packetizer (handshake observation)
r_valid  input  1  R channel valid
r_ready  input  1  R ready as driven by the packetizer
r_last  input  1  RLAST of the current R beat
active_channel  output  2  one-hot grant: [0]=B, [1]=R, 00=none
update_pri  output  2  1-cycle pulse on completion: [0]=B beat done, [1]=R burst done
busy  output  1  grant held (state != IDLE)
burst_err  output  1  sticky; set by the watchdog, cleared only by rst

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, active_channel=00, update_pri=00, busy=0, burst_err=0, r_streak=0, beat_cnt=0. Reset mid-burst aborts the grant; the next grant follows normal arbitration.
- All outputs are registered. The grant appears 1 cycle after arbitration.
- Handshakes: B_hs = b_valid & b_ready & active_channel[0]; R_hs = r_valid & r_ready & active_channel[1]. Handshakes without a grant are ignored.
- States:
  - IDLE: active=00.
    - Only B eligible -> B_XFER. Only R eligible -> R_BURST.
    - Both eligible: R wins if r_streak < R_WEIGHT, else B wins.
    - Neither eligible -> stay in IDLE.
  - B_XFER: active=01. Hold until B_hs; b_valid deassertion does not release the grant.
    - On B_hs: update_pri=01 next cycle; r_streak<=0.
    - Next state: R_BURST if R is eligible that cycle, else IDLE. There is no back-to-back B; B always returns via IDLE or R.
  - R_BURST: active=10. Lock until R_hs with r_last=1. r_valid gaps do not release the grant.
    - Every R_hs increments beat_cnt (width clog2(MAX_BURST_LEN)+1).
    - On the last beat: update_pri=10 next cycle; beat_cnt<=0; r_streak<=min(r_streak+1, R_WEIGHT) (saturating).
    - Next state: B_XFER if B eligible and r_streak(new)>=R_WEIGHT; else R_BURST (new burst, no bubble) if r_valid; else B_XFER if B eligible; else IDLE.
    - Watchdog: if R_hs with r_last=0 occurs when beat_cnt==MAX_BURST_LEN-1, set burst_err, pulse update_pri=10, beat_cnt<=0, and take the end-of-burst transition.
- Eligible: B = HAS_WRITE & b_valid; R = HAS_READ & r_valid.
- update_pri is zero except for the single pulse cycle; at most one bit is set per cycle.
- active_channel is never 11. busy == |active_channel.
- HAS_WRITE=HAS_READ=0: the block stays in IDLE forever.

Test Plan:
- Reset then b_valid=1, b_ready=1 at cycle 0 -> active_channel=01 at cycle 1; B_hs at cycle 1; update_pri=01 at cycle 2; active_channel=00 at cycle 2.
- R burst of 4 beats, r_valid gap of 2 cycles after beat 2, b_valid held high throughout (R_WEIGHT=2, r_streak=0) -> active_channel stays 10 through the gap; update_pri=10 exactly once, 1 cycle after the beat-4 handshake; then B_XFER only if r_streak reached 2, else R continues.
- r_valid and b_valid both continuously high, 1-beat R bursts, R_WEIGHT=2 -> grant sequence R,R,B,R,R,B,… with r_streak resetting to 0 after each B.
- R burst with r_last never asserted, MAX_BURST_LEN=8 -> after the 8th beat, burst_err=1 (sticky), update_pri=10 pulse, grant released; burst_err stays 1 until rst.
- rst asserted during beat 3 of an R burst -> next cycle all outputs 0; state IDLE; the next valid is arbitrated with r_streak=0.
- HAS_READ=0 with r_valid=1, b_valid=1 -> only B granted; active_channel never 10.

Source files
------------

// File: rtl/axi_resp_burst_scheduler.sv
// Response-path sequencer: grants the packetizer to either the B or the R channel,
// locks R for a full burst, and applies a weighted R/B policy when both request.
module axi_resp_burst_scheduler #(
  parameter logic        HAS_WRITE     = 1'b1,
  parameter logic        HAS_READ      = 1'b1,
  parameter int unsigned R_WEIGHT      = 2,
  parameter int unsigned MAX_BURST_LEN = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       b_valid,
  input  logic       b_ready,
  input  logic       r_valid,
  input  logic       r_ready,
  input  logic       r_last,
  output logic [1:0] active_channel,
  output logic [1:0] update_pri,
  output logic       busy,
  output logic       burst_err
);

  localparam int unsigned CNT_W    = $clog2(MAX_BURST_LEN) + 1;
  localparam int unsigned STREAK_W = $clog2(R_WEIGHT + 1);

  localparam logic [STREAK_W-1:0] WEIGHT    = STREAK_W'(R_WEIGHT);
  localparam logic [CNT_W-1:0]    LAST_BEAT = CNT_W'(MAX_BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    B_XFER,
    R_BURST
  } state_e;

  state_e              state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d, streak_inc;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [1:0]          upd_q, upd_d;
  logic [1:0]          active_q, active_d;
  logic                busy_q;

  logic b_elig, r_elig, b_hs, r_hs, wd_fire;

  assign b_elig = HAS_WRITE & b_valid;
  assign r_elig = HAS_READ & r_valid;
  assign b_hs   = b_valid & b_ready & active_q[0];
  assign r_hs   = r_valid & r_ready & active_q[1];

  assign streak_inc = (streak_q >= WEIGHT) ? WEIGHT : streak_q + STREAK_W'(1);
  assign wd_fire    = r_hs & ~r_last & (cnt_q == LAST_BEAT);

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    upd_d    = '0;

    unique case (state_q)
      IDLE: begin
        if (b_elig && r_elig) begin
          state_d = (streak_q < WEIGHT) ? R_BURST : B_XFER;
        end else if (b_elig) begin
          state_d = B_XFER;
        end else if (r_elig) begin
          state_d = R_BURST;
        end
      end

      B_XFER: begin
        if (b_hs) begin
          upd_d    = 2'b01;
          streak_d = '0;
          state_d  = r_elig ? R_BURST : IDLE;
        end
      end

      R_BURST: begin
        if (r_hs) begin
          if (r_last || wd_fire) begin
            // The watchdog closes the burst exactly like a genuine RLAST beat.
            upd_d    = 2'b10;
            cnt_d    = '0;
            streak_d = streak_inc;
            err_d    = err_q | wd_fire;
            if (b_elig && (streak_inc >= WEIGHT)) begin
              state_d = B_XFER;
            end else if (r_valid) begin
              state_d = R_BURST;
            end else if (b_elig) begin
              state_d = B_XFER;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    active_d = '0;
    if (state_d == B_XFER) begin
      active_d = 2'b01;
    end else if (state_d == R_BURST) begin
      active_d = 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      streak_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      upd_q    <= '0;
      active_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      upd_q    <= upd_d;
      active_q <= active_d;
      busy_q   <= |active_d;
    end
  end

  assign active_channel = active_q;
  assign update_pri     = upd_q;
  assign busy           = busy_q;
  assign burst_err      = err_q;

endmodule

// File: tb/tb_axi_resp_burst_scheduler.sv
// Bench for axi_resp_burst_scheduler: a full-featured instance and a write-only
// instance share one stimulus stream and are scored against a transaction-rule model.
module tb_axi_resp_burst_scheduler;

  logic clk = 1'b0;
  logic rst, b_valid, b_ready, r_valid, r_ready, r_last;

  logic [1:0] act0, upd0, act1, upd1;
  logic       busy0, err0, busy1, err1;

  always #5 clk = ~clk;

  axi_resp_burst_scheduler #(
    .HAS_WRITE(1'b1), .HAS_READ(1'b1), .R_WEIGHT(2), .MAX_BURST_LEN(8)
  ) u_dut (
    .clk(clk), .rst(rst),
    .b_valid(b_valid), .b_ready(b_ready),
    .r_valid(r_valid), .r_ready(r_ready), .r_last(r_last),
    .active_channel(act0), .update_pri(upd0), .busy(busy0), .burst_err(err0)
  );

  axi_resp_burst_scheduler #(
    .HAS_WRITE(1'b1), .HAS_READ(1'b0), .R_WEIGHT(2), .MAX_BURST_LEN(8)
  ) u_dut_wonly (
    .clk(clk), .rst(rst),
    .b_valid(b_valid), .b_ready(b_ready),
    .r_valid(r_valid), .r_ready(r_ready), .r_last(r_last),
    .active_channel(act1), .update_pri(upd1), .busy(busy1), .burst_err(err1)
  );

  // owner: 0 = nobody, 1 = B channel, 2 = R channel
  typedef struct {
    int owner;
    int streak;
    int beats;
    bit err;
    int upd;
  } mstate_t;

  function automatic mstate_t step(input mstate_t s, input bit hw, input bit hr,
                                   input int w, input int maxl, input bit rs,
                                   input bit bv, input bit br, input bit rv,
                                   input bit rr, input bit rl);
    mstate_t n;
    bit bel, rel;
    n     = s;
    n.upd = 0;
    bel   = hw && bv;
    rel   = hr && rv;
    if (rs) begin
      n.owner = 0; n.streak = 0; n.beats = 0; n.err = 0;
      return n;
    end
    if (s.owner == 0) begin
      if (bel && rel) n.owner = (s.streak < w) ? 2 : 1;
      else if (bel)   n.owner = 1;
      else if (rel)   n.owner = 2;
    end else if (s.owner == 1) begin
      if (bv && br) begin
        n.upd    = 1;
        n.streak = 0;
        n.owner  = rel ? 2 : 0;
      end
    end else begin
      if (rv && rr) begin
        if (rl || s.beats == maxl - 1) begin
          if (!rl) n.err = 1;
          n.upd    = 2;
          n.beats  = 0;
          n.streak = (s.streak + 1 > w) ? w : s.streak + 1;
          if (bel && n.streak >= w) n.owner = 1;
          else if (rv)              n.owner = 2;
          else if (bel)             n.owner = 1;
          else                      n.owner = 0;
        end else begin
          n.beats = s.beats + 1;
        end
      end
    end
    return n;
  endfunction

  function automatic logic [5:0] expect_vec(input mstate_t s);
    logic [1:0] a;
    a = (s.owner == 1) ? 2'b01 : (s.owner == 2) ? 2'b10 : 2'b00;
    return {s.err, (s.owner != 0), 2'(s.upd), a};
  endfunction

  mstate_t    m0, m1;
  logic [5:0] q0[$];
  logic [5:0] q1[$];
  int         tests = 0;
  int         fails = 0;
  string      phase = "reset";

  initial begin
    m0 = '{0, 0, 0, 1'b0, 0};
    m1 = '{0, 0, 0, 1'b0, 0};
  end

  always @(posedge clk) begin
    m0 = step(m0, 1'b1, 1'b1, 2, 8, rst, b_valid, b_ready, r_valid, r_ready, r_last);
    m1 = step(m1, 1'b1, 1'b0, 2, 8, rst, b_valid, b_ready, r_valid, r_ready, r_last);
    q0.push_back(expect_vec(m0));
    q1.push_back(expect_vec(m1));
  end

  always @(negedge clk) begin
    logic [5:0] e, a;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      a = {err0, busy0, upd0, act0};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL %s full_dut: got %b required %b (err,busy,upd[1:0],active[1:0]) t=%0t",
                 phase, a, e, $time);
      end
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      a = {err1, busy1, upd1, act1};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL %s write_only_dut: got %b required %b (err,busy,upd[1:0],active[1:0]) t=%0t",
                 phase, a, e, $time);
      end
    end
  end

  task automatic cyc(input bit bv, input bit br, input bit rv, input bit rr,
                     input bit rl, input bit rs);
    b_valid = bv; b_ready = br; r_valid = rv; r_ready = rr; r_last = rl; rst = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    phase = "reset";
    repeat (3) cyc(0, 0, 0, 0, 0, 1);

    phase = "b_single";
    repeat (2) cyc(1, 1, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0);

    phase = "r_gap_burst";
    cyc(1, 1, 1, 1, 0, 0);
    repeat (2) cyc(1, 1, 1, 1, 0, 0);
    repeat (2) cyc(1, 1, 0, 1, 0, 0);
    cyc(1, 1, 1, 1, 0, 0);
    cyc(1, 1, 1, 1, 1, 0);
    repeat (2) cyc(1, 1, 0, 1, 0, 0);
    cyc(1, 1, 1, 1, 1, 0);
    repeat (3) cyc(0, 1, 0, 0, 0, 0);

    phase = "weighted_rrb";
    repeat (30) cyc(1, 1, 1, 1, 1, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 1);

    phase = "watchdog";
    repeat (9) cyc(0, 0, 1, 1, 0, 0);
    repeat (3) cyc(1, 1, 1, 1, 1, 0);
    repeat (6) cyc(1, 1, 0, 0, 0, 0);

    phase = "rst_mid_burst";
    repeat (4) cyc(0, 0, 1, 1, 0, 0);
    cyc(0, 0, 1, 1, 0, 1);
    repeat (6) cyc(1, 1, 1, 1, 1, 0);

    phase = "random";
    repeat (3000) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
          $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 299) == 0);
    end

    phase = "drain";
    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
